// File: rtl/yarvi_me.sv
// yarvi memory/commit stage: data RAM with byte-lane delayed stores, extending loads,
// misalignment and load-hit-store detection, and a memory-mapped mtime/mtimecmp timer.
`ifndef XMSB
`define XMSB 31
`endif
`ifndef VMSB
`define VMSB 31
`endif

module yarvi_me #(
  parameter int          DMEM_LOG2  = 12,
  parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           valid,
  input  logic [`VMSB:0] pc,
  input  logic [4:0]     wb_rd,
  input  logic [`XMSB:0] wb_val,
  input  logic           readenable,
  input  logic           writeenable,
  input  logic [2:0]     funct3,
  input  logic [`XMSB:0] writedata,
  output logic           me_valid,
  output logic [`VMSB:0] me_pc,
  output logic [4:0]     me_wb_rd,
  output logic [`XMSB:0] me_wb_val,
  output logic           me_exc_misaligned,
  output logic [`XMSB:0] me_exc_mtval,
  output logic           me_load_hit_store,
  output logic           me_timer_interrupt
);

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << off;
      2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'd0:    r = 32'(b);
      3'd4:    r = {24'd0, b};
      3'd1:    r = 32'(h);
      3'd5:    r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic [31:0]          addr;
  logic [1:0]           size;
  logic [DMEM_LOG2-1:0] ex_idx;
  logic                 is_store, is_load, misaligned, in_timer, tmr_wr;

  logic           me_valid_q, me_valid_d;
  logic [`VMSB:0] me_pc_q, me_pc_d;
  logic [4:0]     me_wb_rd_q, me_wb_rd_d;
  logic [31:0]    alu_val_q, alu_val_d;
  logic           exc_q, exc_d;
  logic [31:0]    mtval_q, mtval_d;
  logic           lhs_q, lhs_d;
  logic           ld_q, ld_d;
  logic           ld_tmr_q, ld_tmr_d;
  logic [2:0]     ld_f3_q, ld_f3_d;
  logic [1:0]     ld_off_q, ld_off_d;
  logic [31:0]    tmr_rdata_q, tmr_rdata_d;
  logic [31:0]    ram_rdata_q;
  logic           st_pend_q, st_pend_d;
  logic [DMEM_LOG2-1:0] st_idx_q, st_idx_d;
  logic [31:0]    st_data_q, st_data_d;
  logic [3:0]     st_mask_q, st_mask_d;
  logic [63:0]    mtime_q, mtime_d;
  logic [63:0]    mtimecmp_q, mtimecmp_d;
  logic           irq_q, irq_d;

  logic [31:0] ram [0:(1<<DMEM_LOG2)-1];

  always_comb begin
    addr       = wb_val;
    size       = funct3[1:0];
    ex_idx     = addr[DMEM_LOG2+1:2];
    is_store   = valid && writeenable;
    is_load    = valid && readenable && !writeenable;
    misaligned = (is_store || is_load) &&
                 ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0));
    in_timer   = (addr[31:4] == TIMER_BASE[31:4]);
    tmr_wr     = is_store && !misaligned && in_timer && size == 2'd2;
  end

  // EX -> ME register inputs
  always_comb begin
    me_valid_d  = valid;
    me_pc_d     = pc;
    me_wb_rd_d  = (valid && !misaligned) ? wb_rd : 5'd0;
    alu_val_d   = wb_val;
    exc_d       = misaligned;
    mtval_d     = misaligned ? addr : 32'd0;
    ld_d        = is_load && !misaligned;
    ld_tmr_d    = in_timer;
    ld_f3_d     = funct3;
    ld_off_d    = addr[1:0];
    // The RAM read at this edge misses the ME store's write, which lands at the same edge.
    lhs_d       = ld_d && !in_timer && st_pend_q && (ex_idx == st_idx_q);
    case (addr[3:2])
      2'd0:    tmr_rdata_d = mtime_q[31:0];
      2'd1:    tmr_rdata_d = mtime_q[63:32];
      2'd2:    tmr_rdata_d = mtimecmp_q[31:0];
      default: tmr_rdata_d = mtimecmp_q[63:32];
    endcase
    st_pend_d   = is_store && !misaligned && !in_timer;
    st_idx_d    = ex_idx;
    st_data_d   = store_lanes(size, writedata);
    st_mask_d   = store_mask(size, addr[1:0]);
    mtime_d     = mtime_q + 64'd1;
    mtimecmp_d  = mtimecmp_q;
    if (tmr_wr) begin
      case (addr[3:2])
        2'd0:    mtime_d = {mtime_q[63:32], writedata};
        2'd1:    mtime_d = {writedata, mtime_q[31:0]};
        2'd2:    mtimecmp_d = {mtimecmp_q[63:32], writedata};
        default: mtimecmp_d = {writedata, mtimecmp_q[31:0]};
      endcase
    end
    irq_d       = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      me_valid_q <= 1'b0;
      me_pc_q    <= '0;
      me_wb_rd_q <= 5'd0;
      alu_val_q  <= 32'd0;
      exc_q      <= 1'b0;
      mtval_q    <= 32'd0;
      lhs_q      <= 1'b0;
      ld_q       <= 1'b0;
      st_pend_q  <= 1'b0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      me_valid_q <= me_valid_d;
      me_pc_q    <= me_pc_d;
      me_wb_rd_q <= me_wb_rd_d;
      alu_val_q  <= alu_val_d;
      exc_q      <= exc_d;
      mtval_q    <= mtval_d;
      lhs_q      <= lhs_d;
      ld_q       <= ld_d;
      st_pend_q  <= st_pend_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clock) begin
    ld_tmr_q    <= ld_tmr_d;
    ld_f3_q     <= ld_f3_d;
    ld_off_q    <= ld_off_d;
    tmr_rdata_q <= tmr_rdata_d;
    st_idx_q    <= st_idx_d;
    st_data_q   <= st_data_d;
    st_mask_q   <= st_mask_d;
  end

  // ME: delayed store commit and synchronous RAM read for the EX load
  always_ff @(posedge clock) begin
    ram_rdata_q <= ram[ex_idx];
    if (st_pend_q && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask_q[b]) ram[st_idx_q][8*b +: 8] <= st_data_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    me_valid           = me_valid_q;
    me_pc              = me_pc_q;
    me_wb_rd           = me_wb_rd_q;
    me_wb_val          = ld_q ? load_extract(ld_tmr_q ? tmr_rdata_q : ram_rdata_q, ld_f3_q, ld_off_q)
                              : alu_val_q;
    me_exc_misaligned  = exc_q;
    me_exc_mtval       = mtval_q;
    me_load_hit_store  = lhs_q;
    me_timer_interrupt = irq_q;
  end

endmodule

// File: tb/tb_yarvi_me.sv
// Bench for yarvi_me: byte-addressed memory/timer model plus directed scenarios and random traffic.
`ifndef XMSB
`define XMSB 31
`endif
`ifndef VMSB
`define VMSB 31
`endif

module tb_yarvi_me;
  localparam logic [31:0] TB = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, re, we;
  logic [31:0] pc, wb_val, wd;
  logic [4:0]  wb_rd;
  logic [2:0]  f3;
  logic        me_valid, me_exc_misaligned, me_load_hit_store, me_timer_interrupt;
  logic [31:0] me_pc, me_wb_val, me_exc_mtval;
  logic [4:0]  me_wb_rd;

  yarvi_me #(.DMEM_LOG2(12), .TIMER_BASE(TB)) dut (
    .clock(clk), .reset(rst), .valid(valid), .pc(pc), .wb_rd(wb_rd), .wb_val(wb_val),
    .readenable(re), .writeenable(we), .funct3(f3), .writedata(wd),
    .me_valid(me_valid), .me_pc(me_pc), .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val),
    .me_exc_misaligned(me_exc_misaligned), .me_exc_mtval(me_exc_mtval),
    .me_load_hit_store(me_load_hit_store), .me_timer_interrupt(me_timer_interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: byte memory, 64-bit timer, pending store as a byte list
  logic [7:0]  mem_b [0:16383];
  logic [63:0] m_time, m_cmp;
  int          pend_n, pend_w;
  int          pend_a [4];
  logic [7:0]  pend_d [4];
  bit          started = 0;
  logic        e_valid, e_exc, e_lhs, e_irq;
  logic [31:0] e_pc, e_val, e_mtval;
  logic [4:0]  e_rd;

  always @(posedge clk) begin : model
    int nb, off, half;
    logic st, ld, mis, tmr;
    logic [31:0] a, v, tw;
    logic [63:0] t_old;
    if (rst) begin
      e_valid = 0; e_exc = 0; e_lhs = 0; e_irq = 0;
      e_pc = 0; e_val = 0; e_mtval = 0; e_rd = 0;
      m_time = 0; m_cmp = '1; pend_n = 0;
    end else begin
      a    = wb_val;
      nb   = 1 << f3[1:0];
      st   = valid && we;
      ld   = valid && re && !we;
      off  = int'(a[1:0]);
      mis  = (st || ld) && (off % nb != 0);
      tmr  = (a >= TB) && (a < TB + 32'd16);
      half = int'((a - TB) / 4);
      e_valid = valid; e_pc = pc; e_exc = mis; e_mtval = mis ? a : 32'd0;
      e_rd = (valid && !mis) ? wb_rd : 5'd0;
      e_val = wb_val; e_lhs = 0;
      if (ld && !mis) begin
        if (tmr) begin
          case (half)
            0: tw = m_time[31:0];
            1: tw = m_time[63:32];
            2: tw = m_cmp[31:0];
            default: tw = m_cmp[63:32];
          endcase
          v = tw >> (8 * off);
          if (nb < 4) v = v & ((32'd1 << (8 * nb)) - 1);
        end else begin
          v = 0;
          for (int i = 0; i < 4; i++)
            if (i < nb) v = v | (32'(mem_b[int'(a & 32'h3FFC) + off + i]) << (8 * i));
          e_lhs = (pend_n > 0) && (int'(a[13:2]) == pend_w);
        end
        if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        e_val = v;
      end
      e_irq = (m_time >= m_cmp);
      for (int i = 0; i < pend_n; i++) mem_b[pend_a[i]] = pend_d[i];
      pend_n = 0;
      t_old = m_time;
      m_time = t_old + 1;
      if (st && !mis && tmr && nb == 4) begin
        case (half)
          0: m_time = {t_old[63:32], wd};
          1: m_time = {wd, t_old[31:0]};
          2: m_cmp[31:0] = wd;
          default: m_cmp[63:32] = wd;
        endcase
      end
      if (st && !mis && !tmr) begin
        pend_n = nb;
        pend_w = int'(a[13:2]);
        for (int i = 0; i < 4; i++) begin
          if (i < nb) begin
            pend_a[i] = int'(a & 32'h3FFF) + i;
            pend_d[i] = wd[8*i +: 8];
          end
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("me_valid", me_valid, e_valid);
      chk("timer_irq", me_timer_interrupt, e_irq);
      if (e_valid) begin
        chk("me_pc", me_pc, e_pc);
        chk("me_wb_rd", me_wb_rd, e_rd);
        chk("me_exc", me_exc_misaligned, e_exc);
        if (e_exc) chk("me_mtval", me_exc_mtval, e_mtval);
        else begin
          chk("me_wb_val", me_wb_val, e_val);
          chk("me_lhs", me_load_hit_store, e_lhs);
        end
      end
    end
  end

  task automatic op(input logic v, input logic r, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    valid = v; re = r; we = w; f3 = f; wb_val = a; wd = d; wb_rd = rd; pc = $urandom;
    @(posedge clk); #1;
    valid = 0; re = 0; we = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  logic [2:0]  lf_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int          kind, waited;
  logic        rv, rre;
  logic [31:0] ra, last_a;

  initial begin
    rst = 1; valid = 0; re = 0; we = 0; f3 = 0; wb_val = 0; wd = 0; wb_rd = 0; pc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", me_valid, 0);
    chk("rst_wb_val", me_wb_val, 0);
    chk("rst_wb_rd", me_wb_rd, 0);
    chk("rst_pc", me_pc, 0);
    chk("rst_exc", {me_exc_misaligned, me_exc_mtval, me_load_hit_store}, 0);
    chk("rst_irq", me_timer_interrupt, 0);
    rst = 0;

    for (int i = 0; i < 256; i++) op(1, 0, 1, 3'd2, 32'(i * 4), $urandom, 5'd0);

    // Word store, then extending loads of the same word
    op(1, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0);
    idle();
    op(1, 1, 0, 3'd2, 32'h100, 0, 5'd5);
    chk("lw_100", me_wb_val, 32'hDEADBEEF);
    chk("lw_100_rd", me_wb_rd, 5'd5);
    op(1, 1, 0, 3'd0, 32'h103, 0, 5'd6);
    chk("lb_103", me_wb_val, 32'hFFFFFFDE);
    op(1, 1, 0, 3'd4, 32'h103, 0, 5'd7);
    chk("lbu_103", me_wb_val, 32'h000000DE);
    op(1, 1, 0, 3'd5, 32'h102, 0, 5'd8);
    chk("lhu_102", me_wb_val, 32'h0000DEAD);

    // Byte stores leave the other lanes alone
    op(1, 0, 1, 3'd2, 32'h200, 32'h0, 5'd0);
    op(1, 0, 1, 3'd2, 32'h204, 32'h11223344, 5'd0);
    op(1, 0, 1, 3'd0, 32'h201, 32'h0000005A, 5'd0);
    op(1, 0, 1, 3'd0, 32'h206, 32'hFFFFFFA5, 5'd0);
    idle();
    op(1, 1, 0, 3'd2, 32'h200, 0, 5'd9);
    chk("sb_201", me_wb_val, 32'h00005A00);
    op(1, 1, 0, 3'd2, 32'h204, 0, 5'd9);
    chk("sb_206", me_wb_val, 32'h11A53344);

    // Misaligned accesses
    op(1, 1, 0, 3'd2, 32'h102, 0, 5'd10);
    chk("mis_lw_exc", me_exc_misaligned, 1);
    chk("mis_lw_mtval", me_exc_mtval, 32'h102);
    chk("mis_lw_rd", me_wb_rd, 0);
    op(1, 0, 1, 3'd1, 32'h101, 32'h12345678, 5'd0);
    chk("mis_sh_exc", me_exc_misaligned, 1);
    chk("mis_sh_mtval", me_exc_mtval, 32'h101);
    idle();
    op(1, 1, 0, 3'd2, 32'h100, 0, 5'd11);
    chk("mis_no_write", me_wb_val, 32'hDEADBEEF);

    // Load-hit-store
    op(1, 0, 1, 3'd2, 32'h300, 32'h55667788, 5'd0);
    op(1, 1, 0, 3'd2, 32'h300, 0, 5'd12);
    chk("lhs_same", me_load_hit_store, 1);
    op(1, 0, 1, 3'd2, 32'h300, 32'h99AABBCC, 5'd0);
    op(1, 1, 0, 3'd2, 32'h304, 0, 5'd12);
    chk("lhs_other", me_load_hit_store, 0);

    // Invalid store and reset-dropped store
    op(0, 0, 1, 3'd2, 32'h100, 32'h12345678, 5'd0);
    chk("inv_valid", me_valid, 0);
    idle();
    op(1, 1, 0, 3'd2, 32'h100, 0, 5'd13);
    chk("inv_no_write", me_wb_val, 32'hDEADBEEF);
    op(1, 0, 1, 3'd2, 32'h100, 32'hCAFEF00D, 5'd0);
    rst = 1;
    idle();
    rst = 0;
    op(1, 1, 0, 3'd2, 32'h100, 0, 5'd14);
    chk("rst_drop_store", me_wb_val, 32'hDEADBEEF);

    // Timer compare
    op(1, 0, 1, 3'd2, TB + 32'd8, 32'd10, 5'd0);
    op(1, 0, 1, 3'd2, TB + 32'd12, 32'd0, 5'd0);
    waited = 0;
    while (!me_timer_interrupt && waited < 60) begin
      idle();
      waited++;
    end
    chk("irq_rise", me_timer_interrupt, 1);
    op(1, 1, 0, 3'd2, TB, 0, 5'd15);
    chk("mtime_ge_10", me_wb_val >= 32'd10, 1);
    op(1, 0, 1, 3'd2, TB + 32'd12, 32'hFFFFFFFF, 5'd0);
    idle();
    chk("irq_drop", me_timer_interrupt, 0);

    // Random traffic
    last_a = 32'h100;
    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 9);
      rv   = ($urandom_range(0, 9) != 0);
      ra   = ($urandom_range(0, 2) == 0) ? {last_a[31:2], 2'($urandom)}
                                         : 32'($urandom_range(0, 1023));
      if (kind <= 3) begin
        op(rv, 1, 0, lf_tab[$urandom_range(0, 4)], ra, $urandom, 5'($urandom));
      end else if (kind <= 6) begin
        rre = ($urandom_range(0, 5) == 0);
        op(rv, rre, 1, 3'($urandom_range(0, 2)), ra, $urandom, 5'($urandom));
        last_a = ra;
      end else if (kind == 7) begin
        op(rv, 0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom));
      end else if (kind == 8) begin
        op(rv, 1, 0, lf_tab[$urandom_range(0, 4)], TB + 32'($urandom_range(0, 15)), 0,
           5'($urandom));
      end else begin
        op(rv, 0, 1, ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd2,
           TB + 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 2000)), 5'd0);
      end
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/yarvi_me.md
Name: yarvi_me

Overview:
- Memory/commit stage directly downstream of yarvi_ex; consumes the EX-stage result and memory request, and produces the architectural writeback (me_*) seen at the yarvi top level.
- Contains the data RAM with byte-lane stores and sign/zero-extending loads, plus misaligned-access detection and load-hit-store detection.
- Also contains a memory-mapped 64-bit mtime/mtimecmp timer that drives me_timer_interrupt.

Parameters:
- DMEM_LOG2, 12, log2 of data RAM size in 32-bit words (default 16 KiB).
- TIMER_BASE, 32'h4000_0000, base of the 16-byte timer window: +0 mtime lo, +4 mtime hi, +8 mtimecmp lo, +12 mtimecmp hi.

Ports:
- clock  in  1  Core clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high reset.
- valid  in  1  ex_valid; EX holds a committed instruction.
- pc  in  `VMSB+1  ex_pc.
- wb_rd  in  5  ex_wb_rd; 0 means no writeback.
- wb_val  in  `XMSB+1  ex_wb_val; ALU result, and the effective address when readenable or writeenable is set.
- readenable  in  1  Load request.
- writeenable  in  1  Store request.
- funct3  in  3  Access size/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0, 1 and 2.
- writedata  in  `XMSB+1  Store data, unshifted.
- me_valid  out  1  ME holds a valid instruction.
- me_pc  out  `VMSB+1  PC of the ME instruction.
- me_wb_rd  out  5  Destination register; forced to 0 on an exception.
- me_wb_val  out  `XMSB+1  Writeback value.
- me_exc_misaligned  out  1  Misaligned load or store in ME.
- me_exc_mtval  out  `XMSB+1  Faulting address.
- me_load_hit_store  out  1  The load in ME read a word being written by the preceding store; the core must restart at me_pc.
- me_timer_interrupt  out  1  Registered (mtime >= mtimecmp), unsigned 64-bit compare.

Behaviour:
- Reset values:
  - me_valid = 0, me_wb_rd = 0, me_wb_val = 0, me_pc = 0.
  - me_exc_misaligned = 0, me_exc_mtval = 0, me_load_hit_store = 0.
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, me_timer_interrupt = 0.
  - RAM contents are not reset.
- Pipeline: a single register stage EX->ME with 1-cycle latency. When valid = 0, me_valid = 0 the next cycle and no RAM or timer state changes.
- Misalignment:
  - Halfword access (funct3[1:0] = 1) with addr[0] = 1 is misaligned.
  - Word access (funct3[1:0] = 2) with addr[1:0] != 0 is misaligned.
  - On misalignment: no RAM/timer access, me_exc_misaligned = 1, me_exc_mtval = addr, me_wb_rd = 0.
- Loads:
  - RAM is read synchronously at word index addr[DMEM_LOG2+1:2]; upper address bits are ignored outside the timer window.
  - The lane is selected in ME using the registered addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - Data is replicated across lanes: byte to all 4 lanes, halfword to both halves.
  - Byte mask: SB 0001<<addr[1:0]; SH 0011<<addr[1]*2; SW 1111.
  - Address, data and mask are registered in EX and written to RAM at the end of the ME cycle (delayed write).
  - A store's me_wb_rd is passed through as given (EX supplies 0).
- Load-hit-store:
  - Condition: a load in EX whose word index equals that of the store currently in ME with its delayed write pending.
  - That load reads stale data, so me_load_hit_store = 1 in its ME cycle.
  - Its writeback is still presented; the top level treats it as restart-and-squash.
  - Only non-excepting ME stores count.
- Timer:
  - mtime increments by 1 every cycle after reset.
  - A store to the window replaces the addressed 32-bit half; SB/SH to the window are ignored.
  - A store to the mtime lo/hi half overrides that cycle's increment.
  - Loads return the 32-bit half sampled at the EX edge.
  - The timer window takes precedence over RAM decode.
  - me_timer_interrupt updates every cycle regardless of valid.
- Non-memory instructions: me_wb_val = registered wb_val.
- Both readenable and writeenable set: illegal, treated as store.
- Reset asserted mid-operation: the pending delayed store is dropped.

Test Plan:
- SW 32'hDEADBEEF @0x100, then LW @0x100 with 1 bubble -> me_wb_val = 32'hDEADBEEF; LB @0x103 -> 32'hFFFFFFDE; LBU @0x103 -> 32'h000000DE; LHU @0x102 -> 32'h0000DEAD.
- SB 8'h5A @0x201 onto word 0 -> LW @0x200 = 32'h00005A00; other lanes unchanged.
- LW @0x102 and SH @0x101 -> me_exc_misaligned = 1, me_exc_mtval = 0x102 / 0x101, me_wb_rd = 0, RAM word 0x100 unchanged.
- SW @0x300 immediately followed by LW @0x300 -> me_load_hit_store = 1 on the load; LW @0x304 in the same position -> 0.
- Reset, store 10 to mtimecmp lo, then 0 to hi -> me_timer_interrupt rises once mtime >= 10. Then store 0xFFFFFFFF to mtimecmp hi -> interrupt drops the following cycle.
- valid = 0 with writeenable = 1 -> no RAM change and me_valid = 0. Assert reset while a store is in ME -> the target word keeps its old value.
